// File: rtl/drawing_priority_n.sv
// drawing_priority_n
// Multi-layer drawing priority mux for the pixel pipeline. Layer 0 has the
// highest priority; when no layer draws, the background colour is shown.
// The chosen colour, winning index and live collision flags are registered
// with one cycle of latency. Collisions are also OR-accumulated per video
// frame and published on each frame_start.
//
// Optional build macro: DRAWING_PRIORITY_TRANSPARENT_KEY_EN
//   When defined, a layer whose colour equals TRANSPARENT_KEY is treated as
//   not drawing, for both priority and collision.

module drawing_priority_n #(
    parameter int NUM_LAYERS = 4,
    parameter int COLOR_W    = 4,
    parameter int IDX_W      = $clog2(NUM_LAYERS)
`ifdef DRAWING_PRIORITY_TRANSPARENT_KEY_EN
    ,
    parameter logic [3*COLOR_W-1:0] TRANSPARENT_KEY =
        {{COLOR_W{1'b0}}, {COLOR_W{1'b1}}, {COLOR_W{1'b0}}}
`endif
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_LAYERS*3*COLOR_W-1:0] RGB_layers,
    input  logic [NUM_LAYERS-1:0]           draw,
    input  logic [NUM_LAYERS-1:0]           layer_en,
    input  logic [3*COLOR_W-1:0]            RGB_bg,
    input  logic                            frame_start,
    output logic [COLOR_W-1:0]              Red_level,
    output logic [COLOR_W-1:0]              Green_level,
    output logic [COLOR_W-1:0]              Blue_level,
    output logic [IDX_W-1:0]                top_layer,
    output logic                            draw_any,
    output logic [NUM_LAYERS-1:0]           coll_live,
    output logic [NUM_LAYERS-1:0]           coll_frame,
    output logic                            coll_frame_valid
);

    localparam int PIX_W = 3 * COLOR_W;
    localparam int CNT_W = $clog2(NUM_LAYERS + 1);

    // Number of set bits in a layer mask.
    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_LAYERS-1:0] mask);
        logic [CNT_W-1:0] cnt;
        cnt = {CNT_W{1'b0}};
        for (int i = 0; i < NUM_LAYERS; i++) begin
            cnt = cnt + CNT_W'(mask[i]);
        end
        return cnt;
    endfunction

    logic [NUM_LAYERS-1:0] active_s;
    logic                  win_found_s;
    logic [IDX_W-1:0]      win_idx_s;
    logic [PIX_W-1:0]      win_rgb_s;
    logic                  multi_s;
    logic [NUM_LAYERS-1:0] coll_next_s;

    logic [PIX_W-1:0]      rgb_r;
    logic [IDX_W-1:0]      top_layer_r;
    logic                  draw_any_r;
    logic [NUM_LAYERS-1:0] coll_live_r;
    logic [NUM_LAYERS-1:0] coll_acc_r;
    logic [NUM_LAYERS-1:0] coll_frame_r;
    logic                  coll_frame_valid_r;

    // Qualify each layer's draw request; the AND with layer_en comes first so
    // unknown data on a disabled layer resolves to inactive.
    always_comb begin
        active_s = {NUM_LAYERS{1'b0}};
        for (int i = 0; i < NUM_LAYERS; i++) begin
`ifdef DRAWING_PRIORITY_TRANSPARENT_KEY_EN
            active_s[i] = draw[i] & layer_en[i] &
                          (RGB_layers[i*PIX_W +: PIX_W] != TRANSPARENT_KEY);
`else
            active_s[i] = draw[i] & layer_en[i];
`endif
        end
    end

    // Priority select: the lowest-numbered active layer wins, else background.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = {IDX_W{1'b0}};
        win_rgb_s   = RGB_bg;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (active_s[i] && !win_found_s) begin
                win_found_s = 1'b1;
                win_idx_s   = IDX_W'(i);
                win_rgb_s   = RGB_layers[i*PIX_W +: PIX_W];
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Live collision: a layer collides when it is active together with another.
    always_comb begin
        multi_s     = (popcount(active_s) >= CNT_W'(2));
        coll_next_s = multi_s ? active_s : {NUM_LAYERS{1'b0}};
    end

    // Pixel output register: colour, winner index, draw flag, live collisions.
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_r       <= {PIX_W{1'b0}};
            top_layer_r <= {IDX_W{1'b0}};
            draw_any_r  <= 1'b0;
            coll_live_r <= {NUM_LAYERS{1'b0}};
        end else begin
            rgb_r       <= win_rgb_s;
            top_layer_r <= win_idx_s;
            draw_any_r  <= win_found_s;
            coll_live_r <= coll_next_s;
        end
    end

    // Frame collision accumulator; the frame_start pixel opens the new frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            coll_acc_r         <= {NUM_LAYERS{1'b0}};
            coll_frame_r       <= {NUM_LAYERS{1'b0}};
            coll_frame_valid_r <= 1'b0;
        end else if (frame_start) begin
            coll_frame_r       <= coll_acc_r;
            coll_acc_r         <= coll_next_s;
            coll_frame_valid_r <= 1'b1;
        end else begin
            coll_acc_r         <= coll_acc_r | coll_next_s;
            coll_frame_valid_r <= 1'b0;
        end
    end

    assign Red_level        = rgb_r[PIX_W-1 -: COLOR_W];
    assign Green_level      = rgb_r[2*COLOR_W-1 -: COLOR_W];
    assign Blue_level       = rgb_r[COLOR_W-1 -: COLOR_W];
    assign top_layer        = top_layer_r;
    assign draw_any         = draw_any_r;
    assign coll_live        = coll_live_r;
    assign coll_frame       = coll_frame_r;
    assign coll_frame_valid = coll_frame_valid_r;

endmodule

// File: tb/tb_drawing_priority_n.sv
// Testbench for drawing_priority_n: directed test-plan steps followed by
// randomized pixels, all checked against a behavioural model of the
// priority, collision and per-frame accumulation rules.

module tb_drawing_priority_n;

    localparam int NL = 4;
    localparam int CW = 4;
    localparam int IW = 2;
    localparam int PW = 3 * CW;
`ifdef DRAWING_PRIORITY_TRANSPARENT_KEY_EN
    localparam logic [PW-1:0] KEY = 12'h0F0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset;
    logic [NL*PW-1:0]     rgb_layers;
    logic [NL-1:0]        draw;
    logic [NL-1:0]        layer_en;
    logic [PW-1:0]        rgb_bg;
    logic                 frame_start;
    logic [CW-1:0]        red, green, blue;
    logic [IW-1:0]        top_layer;
    logic                 draw_any;
    logic [NL-1:0]        coll_live;
    logic [NL-1:0]        coll_frame;
    logic                 coll_frame_valid;

    drawing_priority_n #(.NUM_LAYERS(NL), .COLOR_W(CW)) dut (
        .clk             (clk),
        .reset           (reset),
        .RGB_layers      (rgb_layers),
        .draw            (draw),
        .layer_en        (layer_en),
        .RGB_bg          (rgb_bg),
        .frame_start     (frame_start),
        .Red_level       (red),
        .Green_level     (green),
        .Blue_level      (blue),
        .top_layer       (top_layer),
        .draw_any        (draw_any),
        .coll_live       (coll_live),
        .coll_frame      (coll_frame),
        .coll_frame_valid(coll_frame_valid)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [NL-1:0] m_acc;
    logic [PW-1:0] e_rgb;
    logic [IW-1:0] e_idx;
    logic          e_any;
    logic [NL-1:0] e_cl;
    logic [NL-1:0] e_frame;
    logic          e_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_layer(input int i, input logic [PW-1:0] c);
        rgb_layers[i*PW +: PW] = c;
    endtask

    // Apply one pixel: predict from the current inputs, clock it, compare.
    task automatic step();
        logic [NL-1:0] act;
        logic [NL-1:0] cl;
        logic [PW-1:0] col;
        logic [IW-1:0] idx;
        logic          any;
        act = draw & layer_en;
`ifdef DRAWING_PRIORITY_TRANSPARENT_KEY_EN
        for (int i = 0; i < NL; i++) begin
            if (rgb_layers[i*PW +: PW] === KEY) act[i] = 1'b0;
        end
`endif
        col = rgb_bg;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < NL; i++) begin
            if (!any && act[i] === 1'b1) begin
                any = 1'b1;
                idx = i[IW-1:0];
                col = rgb_layers[i*PW +: PW];
            end
        end
        cl = ($countones(act) >= 2) ? act : '0;
        if (reset) begin
            e_rgb = '0; e_idx = '0; e_any = 1'b0; e_cl = '0;
            m_acc = '0; e_frame = '0; e_valid = 1'b0;
        end else begin
            e_rgb = col; e_idx = idx; e_any = any; e_cl = cl;
            if (frame_start) begin
                e_frame = m_acc;
                m_acc   = cl;
                e_valid = 1'b1;
            end else begin
                m_acc   = m_acc | cl;
                e_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk("rgb", {red, green, blue}, e_rgb);
        chk("top_layer", top_layer, e_idx);
        chk("draw_any", draw_any, e_any);
        chk("coll_live", coll_live, e_cl);
        chk("coll_frame", coll_frame, e_frame);
        chk("coll_frame_valid", coll_frame_valid, e_valid);
    endtask

    initial begin
        m_acc = '0;
        reset = 1'b1;
        draw = 4'b1111;
        layer_en = 4'b1111;
        rgb_layers = 48'h123_456_789_ABC;
        rgb_bg = 12'h555;
        frame_start = 1'b0;
        @(negedge clk);

        // Reset held two cycles with all layers drawing
        step();
        step();
        chk("reset_rgb", {red, green, blue}, 12'h000);
        chk("reset_valid", coll_frame_valid, 1'b0);
        reset = 1'b0;

        // Priority between layers 0 and 2
        draw = 4'b0101;
        set_layer(0, 12'hF00);
        set_layer(2, 12'h00F);
        step();
        chk("prio_rgb", {red, green, blue}, 12'hF00);
        chk("prio_top", top_layer, 2'd0);
        chk("prio_coll", coll_live, 4'b0101);
        layer_en = 4'b1110;
        step();
        chk("mask_rgb", {red, green, blue}, 12'h00F);
        chk("mask_top", top_layer, 2'd2);
        chk("mask_coll", coll_live, 4'b0000);
        layer_en = 4'b1111;

        // Background
        draw = 4'b0000;
        rgb_bg = 12'hFFF;
        step();
        chk("bg_rgb", {red, green, blue}, 12'hFFF);
        chk("bg_any", draw_any, 1'b0);

        // Frame accumulation
        frame_start = 1'b1; step(); frame_start = 1'b0;
        for (int k = 0; k < 9; k++) step();
        draw = 4'b0011; step(); draw = 4'b0000;
        for (int k = 0; k < 3; k++) step();
        frame_start = 1'b1; step(); frame_start = 1'b0;
        chk("frame_pub", coll_frame, 4'b0011);
        chk("frame_valid", coll_frame_valid, 1'b1);
        step();
        chk("frame_valid_drop", coll_frame_valid, 1'b0);
        for (int k = 0; k < 4; k++) step();

        // Collision on the frame_start pixel belongs to the new frame
        draw = 4'b1100;
        frame_start = 1'b1; step(); frame_start = 1'b0;
        chk("fs_pub_empty", coll_frame, 4'b0000);
        draw = 4'b0000;
        for (int k = 0; k < 3; k++) step();
        frame_start = 1'b1; step(); frame_start = 1'b0;
        chk("fs_pub_next", coll_frame, 4'b1100);

        // Back-to-back frame_start pulses
        draw = 4'b0110;
        frame_start = 1'b1; step(); step(); frame_start = 1'b0;
        chk("b2b_pub", coll_frame, 4'b0110);

        // Transparency key stimulus
        draw = 4'b0011;
        set_layer(0, 12'h0F0);
        set_layer(1, 12'h123);
        step();
`ifdef DRAWING_PRIORITY_TRANSPARENT_KEY_EN
        chk("key_rgb", {red, green, blue}, 12'h123);
        chk("key_top", top_layer, 2'd1);
        chk("key_coll", coll_live, 4'b0000);
`else
        chk("key_rgb", {red, green, blue}, 12'h0F0);
        chk("key_coll", coll_live, 4'b0011);
`endif

        // Mid-frame reset then resume
        draw = 4'b1111;
        reset = 1'b1; step(); reset = 1'b0;
        step();

        // Randomized pixels, with X on disabled layers
        for (int n = 0; n < 600; n++) begin
            layer_en = 4'($urandom);
            draw = 4'($urandom);
            rgb_bg = 12'($urandom);
            for (int i = 0; i < NL; i++) begin
                set_layer(i, 12'($urandom));
`ifdef DRAWING_PRIORITY_TRANSPARENT_KEY_EN
                if ($urandom_range(0, 7) == 0) set_layer(i, KEY);
`endif
                if (!layer_en[i] && $urandom_range(0, 3) == 0) begin
                    draw[i] = 1'bx;
                    set_layer(i, 'x);
                end
            end
            frame_start = ($urandom_range(0, 15) == 0);
            reset = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 1'b0;
        frame_start = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/drawing_priority_n.md
Name: drawing_priority_n

Overview:
- Parametrised successor to the two-layer drawing priority mux: selects the colour of the highest-priority drawing layer out of NUM_LAYERS, falls back to a background colour, and registers the result for the screen controller.
- Also reports per-layer overlap (collision) live and accumulated per video frame, so game units can consume frame-stable collision flags.
- Sits between the object units (Intel, Ghost, asteroids, ...) and the screen control block, in the pixel clock domain.

Parameters:
- NUM_LAYERS, 4, number of drawing layers (2..16); layer 0 has the highest priority.
- COLOR_W, 4, bits per colour channel.
- IDX_W, $clog2(NUM_LAYERS), width of the winning-layer index (derived; do not override).

Ports:
- clk  in  1  pixel clock.
- reset  in  1  synchronous reset, active-high.
- RGB_layers  in  NUM_LAYERS*3*COLOR_W  packed {R,G,B} per layer; layer i occupies bits [(i+1)*3*COLOR_W-1 : i*3*COLOR_W].
- draw  in  NUM_LAYERS  per-layer draw request for the current pixel.
- layer_en  in  NUM_LAYERS  per-layer enable mask; a disabled layer neither draws nor collides.
- RGB_bg  in  3*COLOR_W  background colour.
- frame_start  in  1  one-cycle pulse marking the first pixel of a frame.
- Red_level  out  COLOR_W  registered red.
- Green_level  out  COLOR_W  registered green.
- Blue_level  out  COLOR_W  registered blue.
- top_layer  out  IDX_W  registered index of the winning layer (0 when none).
- draw_any  out  1  registered: some layer won this pixel.
- coll_live  out  NUM_LAYERS  registered: layer i active together with at least one other active layer.
- coll_frame  out  NUM_LAYERS  collision flags accumulated over the last complete frame.
- coll_frame_valid  out  1  one-cycle pulse when coll_frame updates.

Behaviour:
- active[i] = draw[i] & layer_en[i] (further qualified by the optional feature).
- Winner: the lowest i with active[i]=1. Output colour = RGB_layers slice i; if no layer is active, RGB_bg with draw_any=0 and top_layer=0.
- Latency: exactly 1 clk from inputs to Red/Green/Blue_level, top_layer, draw_any and coll_live. No throughput bubbles; a new pixel is accepted every cycle.
- coll_live_next[i] = active[i] & (popcount(active) >= 2).
- Accumulator coll_acc (internal, NUM_LAYERS bits):
  - Non-frame_start cycle: coll_acc <= coll_acc | coll_live_next.
  - frame_start cycle: that pixel belongs to the new frame. coll_frame <= coll_acc; coll_acc <= coll_live_next; coll_frame_valid <= 1 on the next cycle only.
- Two frame_start pulses on consecutive cycles: the second pulse publishes an accumulator holding only the first pixel's collisions. This is legal.
- Reset (any cycle, including mid-frame): all outputs and coll_acc become 0, colour outputs become 0, coll_frame_valid=0. The first frame_start after reset publishes a partial-frame result; this is legal.
- Inputs with X on disabled layers must not propagate to any output.

Optional Feature:
- Macro: DRAWING_PRIORITY_TRANSPARENT_KEY_EN.
- Defined: adds parameter TRANSPARENT_KEY (default 12'h0F0 for COLOR_W=4, i.e. 3*COLOR_W bits). A layer whose colour equals TRANSPARENT_KEY is treated as inactive (draw[i] ignored) for both priority and collision, so the pixel falls through to lower layers or the background.
- Not defined: the key is not compared; every colour value is opaque.

Test Plan:
- Reset: hold reset for 2 cycles with draw=4'b1111 → all outputs 0 and coll_frame_valid=0; release → outputs follow inputs 1 cycle later.
- Priority: draw=4'b0101, layer0=12'hF00, layer2=12'h00F → next cycle RGB=F,0,0, top_layer=0, draw_any=1, coll_live=4'b0101. Then layer_en=4'b1110 → RGB=0,0,F, top_layer=2, coll_live=0.
- Background: draw=0, RGB_bg=12'hFFF → RGB=F,F,F, draw_any=0, top_layer=0.
- Frame accumulate: frame_start; 10 cycles later one cycle with draw=4'b0011; next frame_start → following cycle coll_frame=4'b0011 with coll_frame_valid=1 for exactly 1 cycle; the next frame with no overlap publishes 4'b0000.
- Collision on frame_start: draw=4'b1100 on the frame_start cycle → published coll_frame excludes 4'b1100; the following frame's publication includes 4'b1100.
- Transparency (macro defined): layer0=12'h0F0, draw=4'b0011, layer1=12'h123 → RGB=1,2,3, top_layer=1, coll_live=0. With the macro undefined the same stimulus gives RGB=0,F,0, coll_live=4'b0011.
